// File: rtl/accum_pkg.sv
// accum_pkg: shared widths and FSM state type for the accumulating window sequencer.
package accum_pkg;
  localparam int IN_W = 16;
  localparam int SUM_W = 20;
  localparam int MAX_WIN_LOG2 = 4;
  localparam int DROP_W = 8;
  localparam int CNT_W = MAX_WIN_LOG2 + 1;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_e;
endpackage

// File: rtl/window_counter.sv
// window_counter: per-window sample counter with clear, increment and last-sample decode.
module window_counter
  import accum_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << WIN_LOG2) - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    last_o = inc_i && cnt_q == LAST;
    cnt_d = (clr_i || last_o) ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/accum_sequencer.sv
// accum_sequencer: sums 2^WIN_LOG2 signed samples per window and holds sum/mean until accepted.
// Define ACCUM_SEQ_DROP_COUNT_EN to count samples discarded while a result is pending.
module accum_sequencer
  import accum_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [IN_W-1:0]   out_mean,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);
  state_e state_q, state_d;
  logic take, last, run;
  logic signed [SUM_W-1:0] sum_q, sum_d, sum_add;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [IN_W-1:0] out_mean_q, out_mean_d;

  assign run = state_q == S_ACCUM && enable;
  assign take = run && in_valid;

  window_counter #(.WIN_LOG2(WIN_LOG2)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!run),
    .inc_i  (take),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = enable ? S_ACCUM : S_IDLE;
      S_ACCUM: state_d = !enable ? S_IDLE : last ? S_HOLD : S_ACCUM;
      S_HOLD:  state_d = !out_ready ? S_HOLD : enable ? S_ACCUM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = state_q == S_HOLD;
    busy = state_q != S_IDLE;
    out_sum = out_sum_q;
    out_mean = out_mean_q;
  end

  // Leaving ACCUM for any reason (disable or completed window) clears the running sum.
  always_comb begin
    sum_add = sum_q + {{(SUM_W-IN_W){in_data[IN_W-1]}}, in_data};
    sum_d = (!run || last) ? '0 : take ? sum_add : sum_q;
    out_sum_d = last ? sum_add : out_sum_q;
    out_mean_d = last ? IN_W'(sum_add >>> WIN_LOG2) : out_mean_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sum_q <= '0;
      out_sum_q <= '0;
      out_mean_q <= '0;
    end else begin
      sum_q <= sum_d;
      out_sum_q <= out_sum_d;
      out_mean_q <= out_mean_d;
    end

`ifdef ACCUM_SEQ_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;
  assign drop_d = (state_q == S_HOLD && in_valid && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) drop_q <= '0;
    else drop_q <= drop_d;
  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: directed checks of window sums, hold/handshake, disable and reset behaviour.
module tb_accum_sequencer;
  logic clk = 1'b0;
  logic reset, enable, in_valid, out_ready;
  logic [15:0] in_data;
  logic v2, v4, v0, b2, b4, b0;
  logic [19:0] s2, s4, s0;
  logic [15:0] m2, m4, m0;
  logic [7:0] d2, d4, d0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  accum_sequencer #(.WIN_LOG2(2)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v2), .out_ready(out_ready), .out_sum(s2), .out_mean(m2), .busy(b2), .drop_count(d2));
  accum_sequencer #(.WIN_LOG2(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v4), .out_ready(out_ready), .out_sum(s4), .out_mean(m4), .busy(b4), .drop_count(d4));
  accum_sequencer #(.WIN_LOG2(0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v0), .out_ready(out_ready), .out_sum(s0), .out_mean(m0), .busy(b0), .drop_count(d0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic restart();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    enable = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] exp_drop;
    logic [4:0] pat;
`ifdef ACCUM_SEQ_DROP_COUNT_EN
    exp_drop = 8'd3;
`else
    exp_drop = 8'd0;
`endif
    pat = 5'b01101;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("rst_valid", {31'd0, v2}, 32'd0);
    check("rst_busy", {31'd0, b2}, 32'd0);
    check("rst_sum", {12'd0, s2}, 32'd0);
    check("rst_mean", {16'd0, m2}, 32'd0);
    check("rst_drop", {24'd0, d2}, 32'd0);
    reset = 1'b1;
    step();
    check("idle_busy", {31'd0, b2}, 32'd0);
    enable = 1'b1;
    step();
    check("accum_busy", {31'd0, b2}, 32'd1);
    // 100+200+300+400
    send(16'd100); send(16'd200); send(16'd300);
    check("w1_early", {31'd0, v2}, 32'd0);
    send(16'd400);
    check("w1_valid", {31'd0, v2}, 32'd1);
    check("w1_sum", {12'd0, s2}, 32'd1000);
    check("w1_mean", {16'd0, m2}, 32'd250);
    accept();
    check("w1_drop_valid", {31'd0, v2}, 32'd0);
    // four samples of -1
    for (int i = 0; i < 4; i++) send(16'hFFFF);
    check("neg_sum", {12'd0, s2}, 32'h000FFFFC);
    check("neg_mean", {16'd0, m2}, 32'h0000FFFF);
    accept();
    // pending result with dropped samples
    send(16'd5); send(16'd6); send(16'd7); send(16'd8);
    check("hold_sum0", {12'd0, s2}, 32'd26);
    check("hold_mean0", {16'd0, m2}, 32'd6);
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i];
      in_data = 16'd1000;
      step();
      check("hold_valid", {31'd0, v2}, 32'd1);
      check("hold_sum", {12'd0, s2}, 32'd26);
      check("hold_mean", {16'd0, m2}, 32'd6);
    end
    in_valid = 1'b0;
    check("drop_count", {24'd0, d2}, {24'd0, exp_drop});
    accept();
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    check("post_drop_sum", {12'd0, s2}, 32'd10);
    check("post_drop_mean", {16'd0, m2}, 32'd2);
    accept();
    // partial window abandoned by disable; the sample on the disable cycle is ignored
    send(16'd7); send(16'd9);
    enable = 1'b0;
    send(16'd500);
    check("dis_busy", {31'd0, b2}, 32'd0);
    enable = 1'b1;
    step();
    send(16'd10); send(16'd20);
    check("dis_no_valid", {31'd0, v2}, 32'd0);
    send(16'd30);
    check("dis_no_valid3", {31'd0, v2}, 32'd0);
    send(16'd40);
    check("dis_sum", {12'd0, s2}, 32'd100);
    check("dis_mean", {16'd0, m2}, 32'd25);
    accept();
    // async reset in HOLD, away from any clock edge
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    check("pre_rst_valid", {31'd0, v2}, 32'd1);
    reset = 1'b0;
    #2;
    check("async_valid", {31'd0, v2}, 32'd0);
    check("async_busy", {31'd0, b2}, 32'd0);
    check("async_sum", {12'd0, s2}, 32'd0);
    reset = 1'b1;
    step();
    send(16'd11);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
    send(16'd10); send(16'd20); send(16'd30);
    check("rst_mid_no_valid", {31'd0, v2}, 32'd0);
    send(16'd40);
    check("after_rst_sum", {12'd0, s2}, 32'd100);
    check("after_rst_mean", {16'd0, m2}, 32'd25);
    // WIN_LOG2=4 extremes
    restart();
    for (int i = 0; i < 16; i++) send(16'h8000);
    check("min_valid", {31'd0, v4}, 32'd1);
    check("min_sum", {12'd0, s4}, 32'h00080000);
    check("min_mean", {16'd0, m4}, 32'h00008000);
    accept();
    for (int i = 0; i < 15; i++) send(16'h7FFF);
    check("max_early", {31'd0, v4}, 32'd0);
    send(16'h7FFF);
    check("max_sum", {12'd0, s4}, 32'h0007FFF0);
    check("max_mean", {16'd0, m4}, 32'h00007FFF);
    // WIN_LOG2=0: one result per sample
    restart();
    send(16'hFFF0);
    check("w0_valid", {31'd0, v0}, 32'd1);
    check("w0_sum", {12'd0, s0}, 32'h000FFFF0);
    check("w0_mean", {16'd0, m0}, 32'h0000FFF0);
    accept();
    send(16'd123);
    check("w0_sum2", {12'd0, s0}, 32'd123);
    check("w0_mean2", {16'd0, m0}, 32'd123);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
